// File: rtl/led_stream_pkg.sv
`default_nettype none
// led_stream_pkg: mode encoding, default half-period width and prescaler helper for led_stream_multi (rev 1.0).
package led_stream_pkg;

   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PULSE = 2'd3
   } led_mode_t;

   localparam int DEFAULT_PERIOD_W = 16;

   function automatic logic [31:0] pre_max(input int clock_freq, input int tick_hz);
      return 32'(clock_freq / tick_hz - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// led_channel: one LED channel holding its mode, half-period, tick counter and raw output state (rev 1.0).
module led_channel
   import led_stream_pkg::*;
#(
   parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic                restart,
   input  logic                we,
   input  logic [1:0]          wmode,
   input  logic [PERIOD_W-1:0] whp,
   output logic                state,
   output logic                busy
);

   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

   led_mode_t           mode;
   logic [PERIOD_W-1:0] half_period;
   logic [PERIOD_W-1:0] cnt;
   logic                expire;
   logic                counting;

   assign expire   = (cnt == half_period - ONE);
   assign counting = (mode == LED_BLINK) || (mode == LED_PULSE);

   // A write lands on top of a restart: both clear cnt, and the write's mode decides the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode        <= LED_OFF;
         half_period <= ONE;
         cnt         <= '0;
         state       <= 1'b0;
      end else if (we) begin
         mode        <= led_mode_t'(wmode);
         half_period <= (whp == '0) ? ONE : whp;
         cnt         <= '0;
         state       <= (led_mode_t'(wmode) != LED_OFF);
      end else if (restart) begin
         cnt <= '0;
         if (counting) state <= 1'b1;
      end else if (tick && counting) begin
         if (expire) begin
            cnt <= '0;
            if (mode == LED_BLINK) begin
               state <= ~state;
            end else begin
               state <= 1'b0;
               mode  <= LED_OFF;
            end
         end else begin
            cnt <= cnt + ONE;
         end
      end
   end

   assign busy = (mode == LED_PULSE);

endmodule
`default_nettype wire

// File: rtl/led_stream_multi.sv
`default_nettype none
// led_stream_multi: NUM_LEDS runtime-configurable LED channels sharing one prescaler tick (rev 1.0).
// Optional PWM dimming is enabled by defining LED_STREAM_MULTI_DIM_EN.
module led_stream_multi
   import led_stream_pkg::*;
#(
   parameter  int CLOCK_FREQ = 50000000,
   parameter  int TICK_HZ    = 1000,
   parameter  int NUM_LEDS   = 4,
   parameter  int PERIOD_W   = DEFAULT_PERIOD_W,
   localparam int CH_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_half_period,
   input  logic                sync_restart,
`ifdef LED_STREAM_MULTI_DIM_EN
   input  logic [3:0]          cfg_duty,
`endif
   output logic [NUM_LEDS-1:0] led,
   output logic [NUM_LEDS-1:0] pulse_busy,
   output logic                tick
);

   localparam logic [31:0] PRE_MAX = pre_max(CLOCK_FREQ, TICK_HZ);

   logic [31:0] pre_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (sync_restart) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (pre_cnt == PRE_MAX) begin
         pre_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 32'd1;
         tick    <= 1'b0;
      end
   end

`ifdef LED_STREAM_MULTI_DIM_EN
   logic [3:0] pwm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm <= 4'd0;
      else        pwm <= pwm + 4'd1;
   end
`endif

   // Out-of-range cfg_ch values never match a channel index, so such writes are dropped.
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      logic sel;
      logic raw;

      assign sel = cfg_we && (cfg_ch == CH_W'(i));

      led_channel #(
         .PERIOD_W (PERIOD_W)
      ) u_channel (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick    (tick),
         .restart (sync_restart),
         .we      (sel),
         .wmode   (cfg_mode),
         .whp     (cfg_half_period),
         .state   (raw),
         .busy    (pulse_busy[i])
      );

`ifdef LED_STREAM_MULTI_DIM_EN
      logic [3:0] duty;
      logic       lit;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty <= 4'hF;
            lit  <= 1'b0;
         end else begin
            if (sel) duty <= cfg_duty;
            lit <= raw & (pwm < duty);
         end
      end

      assign led[i] = lit;
`else
      assign led[i] = raw;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_led_stream_multi.sv
`default_nettype none
// tb_led_stream_multi: table-driven scoreboard bench for led_stream_multi (4 channels plus a 3-channel twin).
module tb_led_stream_multi;
   import led_stream_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic        sync_restart = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [1:0]  cfg_mode = '0;
   logic [15:0] cfg_half_period = '0;
   logic [3:0]  led, busy;
   logic        tick;
   logic [2:0]  led3, busy3;
   logic        tick3;
`ifdef LED_STREAM_MULTI_DIM_EN
   logic [3:0]  cfg_duty = 4'hF;
`endif

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   typedef struct {
      int          at;
      bit          we;
      logic [1:0]  ch;
      logic [1:0]  mode;
      logic [15:0] hp;
      bit          rs;
      logic [3:0]  led;
      logic [3:0]  busy;
      bit          tick;
   } vec_t;

   vec_t vec[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   led_stream_multi #(.CLOCK_FREQ(1000), .TICK_HZ(100), .NUM_LEDS(4), .PERIOD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_half_period(cfg_half_period), .sync_restart(sync_restart),
`ifdef LED_STREAM_MULTI_DIM_EN
      .cfg_duty(cfg_duty),
`endif
      .led(led), .pulse_busy(busy), .tick(tick)
   );

   // Three-channel twin: a write to channel 3 is out of range for it and must be ignored.
   led_stream_multi #(.CLOCK_FREQ(1000), .TICK_HZ(100), .NUM_LEDS(3), .PERIOD_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_half_period(cfg_half_period), .sync_restart(sync_restart),
`ifdef LED_STREAM_MULTI_DIM_EN
      .cfg_duty(cfg_duty),
`endif
      .led(led3), .pulse_busy(busy3), .tick(tick3)
   );

   function automatic vec_t v(int at, bit we, logic [1:0] ch, logic [1:0] mode, logic [15:0] hp,
                              bit rs, logic [3:0] l, logic [3:0] b, bit t);
      vec_t r;
      r.at = at; r.we = we; r.ch = ch; r.mode = mode; r.hp = hp;
      r.rs = rs; r.led = l; r.busy = b; r.tick = t;
      return r;
   endfunction

   task automatic chk(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", name, at, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      int   cnt0, cnt1;

      // at, we, ch, mode, hp, restart, led, busy, tick (edges counted from reset release)
      vec.push_back(v(  1, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v(  9, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v( 10, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 1));
      vec.push_back(v( 11, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v( 20, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 1));
      vec.push_back(v( 35, 1, 0, LED_BLINK,  3, 0, 4'b0001, 4'b0000, 0));
      vec.push_back(v( 36, 0, 0, 0,          0, 0, 4'b0001, 4'b0000, 0));
      vec.push_back(v( 60, 0, 0, 0,          0, 0, 4'b0001, 4'b0000, 1));
      vec.push_back(v( 61, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v( 90, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 1));
      vec.push_back(v( 91, 0, 0, 0,          0, 0, 4'b0001, 4'b0000, 0));
      vec.push_back(v( 95, 1, 2, LED_PULSE,  5, 0, 4'b0101, 4'b0100, 0));
      vec.push_back(v(120, 0, 0, 0,          0, 0, 4'b0101, 4'b0100, 1));
      vec.push_back(v(121, 0, 0, 0,          0, 0, 4'b0100, 4'b0100, 0));
      vec.push_back(v(140, 0, 0, 0,          0, 0, 4'b0100, 4'b0100, 1));
      vec.push_back(v(141, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v(151, 0, 0, 0,          0, 0, 4'b0001, 4'b0000, 0));
      vec.push_back(v(161, 1, 1, LED_BLINK,  2, 0, 4'b0011, 4'b0000, 0));
      vec.push_back(v(165, 1, 3, LED_ON,     0, 0, 4'b1011, 4'b0000, 0));
      vec.push_back(v(171, 0, 0, 0,          0, 0, 4'b1011, 4'b0000, 0));
      vec.push_back(v(181, 0, 0, 0,          0, 0, 4'b1000, 4'b0000, 0));
      vec.push_back(v(185, 1, 0, LED_BLINK,  2, 0, 4'b1001, 4'b0000, 0));
      vec.push_back(v(186, 1, 3, LED_BLINK,  7, 0, 4'b1001, 4'b0000, 0));
      vec.push_back(v(201, 0, 0, 0,          0, 0, 4'b1010, 4'b0000, 0));
      vec.push_back(v(211, 0, 0, 0,          0, 0, 4'b1010, 4'b0000, 0));
      vec.push_back(v(215, 0, 0, 0,          0, 1, 4'b1011, 4'b0000, 0));
      vec.push_back(v(220, 0, 0, 0,          0, 0, 4'b1011, 4'b0000, 0));
      vec.push_back(v(225, 0, 0, 0,          0, 0, 4'b1011, 4'b0000, 1));
      vec.push_back(v(236, 0, 0, 0,          0, 0, 4'b1000, 4'b0000, 0));
      vec.push_back(v(246, 0, 0, 0,          0, 0, 4'b1000, 4'b0000, 0));
      vec.push_back(v(256, 0, 0, 0,          0, 0, 4'b1011, 4'b0000, 0));
      vec.push_back(v(266, 0, 0, 0,          0, 0, 4'b1011, 4'b0000, 0));
      vec.push_back(v(276, 0, 0, 0,          0, 0, 4'b1000, 4'b0000, 0));
      vec.push_back(v(285, 0, 0, 0,          0, 0, 4'b1000, 4'b0000, 1));
      vec.push_back(v(286, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v(290, 1, 2, LED_BLINK,  0, 0, 4'b0100, 4'b0000, 0));
      vec.push_back(v(296, 0, 0, 0,          0, 0, 4'b0011, 4'b0000, 0));
      vec.push_back(v(306, 0, 0, 0,          0, 0, 4'b0111, 4'b0000, 0));
      vec.push_back(v(310, 1, 1, LED_OFF,    4, 0, 4'b0101, 4'b0000, 0));
      vec.push_back(v(316, 0, 0, 0,          0, 0, 4'b0000, 4'b0000, 0));
      vec.push_back(v(326, 0, 0, 0,          0, 0, 4'b0100, 4'b0000, 0));
      vec.push_back(v(330, 1, 1, LED_PULSE,  9, 0, 4'b0110, 4'b0010, 0));
      vec.push_back(v(335, 0, 0, 0,          0, 0, 4'b0110, 4'b0010, 1));

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vec[k]) begin
         while (edge_n < vec[k].at - 1) begin
            @(posedge clk); #1;
            edge_n++;
         end
         cfg_we          = vec[k].we;
         cfg_ch          = vec[k].ch;
         cfg_mode        = vec[k].mode;
         cfg_half_period = vec[k].hp;
         sync_restart    = vec[k].rs;
         sb.push_back(vec[k]);
         @(posedge clk); #1;
         edge_n++;
         cfg_we       = 1'b0;
         sync_restart = 1'b0;
         e = sb.pop_front();
`ifndef LED_STREAM_MULTI_DIM_EN
         chk("led", e.at, 32'(led), 32'(e.led));
         chk("led_3ch", e.at, 32'(led3), 32'(e.led[2:0]));
`endif
         chk("pulse_busy", e.at, 32'(busy), 32'(e.busy));
         chk("pulse_busy_3ch", e.at, 32'(busy3), 32'(e.busy[2:0]));
         chk("tick", e.at, 32'(tick), 32'(e.tick));
         chk("tick_3ch", e.at, 32'(tick3), 32'(e.tick));
      end

      // Asynchronous reset in the middle of a cycle must clear outputs without waiting for a clock.
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_led", edge_n, 32'(led), 32'd0);
      chk("async_rst_busy", edge_n, 32'(busy), 32'd0);
      chk("async_rst_tick", edge_n, 32'(tick), 32'd0);

`ifdef LED_STREAM_MULTI_DIM_EN
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = LED_ON; cfg_half_period = 16'd1; cfg_duty = 4'd4;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         cnt0 += int'(led[0]);
         cnt1 += int'(led[1]);
      end
      chk("dim_duty4_lit_cycles", 0, 32'(cnt0), 32'd4);
      chk("dim_off_channel_dark", 0, 32'(cnt1), 32'd0);

      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = LED_ON; cfg_duty = 4'd0;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      cnt0 = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         cnt0 += int'(led[0]);
      end
      chk("dim_duty0_dark", 0, 32'(cnt0), 32'd0);

      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = LED_ON; cfg_duty = 4'd15;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      cnt0 = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         cnt0 += int'(led[0]);
      end
      chk("dim_duty15_lit_cycles", 0, 32'(cnt0), 32'd15);

      #2 rst_n = 1'b0;
      #1;
      chk("dim_async_rst_led", 0, 32'(led), 32'd0);
`else
      cnt0 = 0;
      cnt1 = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
